word16_to_byte_serializer: RTL and testbench
============================================

Name: word16_to_byte_serializer

Overview:
- Downstream consumer of the 16-bit word bus; serializes each word into two sequential bytes on an 8-bit valid/ready stream.
- Feeds byte-wide sinks such as UART TX, SPI shift stage or byte-wide memory ports.
- A small word FIFO decouples the producer from output backpressure.
- Byte order is selectable; the default emits bits [7:0] first, then [15:8].

Parameters:
- LSB_FIRST, 1, 1 = emit bits [7:0] then [15:8]; 0 = the reverse.
- FIFO_DEPTH, 2, word FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  16  word from producer
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- out_data  output  8  current byte
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts the byte
- out_last  output  1  high while the second byte of a word is presented
- fifo_level  output  $clog2(FIFO_DEPTH+1)  words stored in the FIFO (excludes the word in the output register)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0 the block clears everything immediately:
  - FIFO pointers and count go to 0.
  - The output register goes to 0, phase goes to 0 and out_valid goes to 0.
  - out_data=0, out_last=0, fifo_level=0.
  - in_ready is forced 0 while rst_n is low.
- Reset mid-word: any partially sent word and all queued words are discarded, with no further bytes. After release, in_ready=1 on the first cycle.
- Input handshake: a word transfers on a rising edge when in_valid && in_ready.
  - in_ready = rst_n && (fifo_level != FIFO_DEPTH).
  - in_ready has no combinational path from out_ready.
- FIFO write/read per edge:
  - A push with no pop increments the count.
  - A pop with no push decrements the count.
  - Simultaneous push and pop leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pushes are never accepted when full. Pops never occur when empty.
- Output register load: the FIFO head is popped into the 16-bit output register on an edge when the FIFO is non-empty and either condition holds:
  - (a) out_valid=0, or
  - (b) out_valid && out_ready && phase=1.
- Loading sets out_valid=1 and phase=0.
- Byte selection: first byte = LSB_FIRST ? word[7:0] : word[15:8]; the second byte is the other half. out_last = out_valid && phase.
- Output handshake:
  - On out_valid && out_ready with phase=0: phase becomes 1.
  - On out_valid && out_ready with phase=1: either reload (rule above), or, if the FIFO is empty, out_valid becomes 0.
- Stall: while out_valid && !out_ready, out_data, out_last and phase hold stable.
- Idle: when out_valid=0, out_data holds its last value (0 after reset). Sinks must ignore it.
- Latency:
  - A word accepted at edge E into an empty block is loaded at edge E+1.
  - Its first byte is visible after E+1; with out_ready=1 its second byte is visible after E+2.
  - Steady-state throughput is 1 byte/cycle, i.e. 1 word per 2 cycles, with no bubble between consecutive words.
- Full: a simultaneous push while full and a pop on the same edge does not occur, because in_ready=0 when full. in_ready rises the cycle after the pop.
- No data loss or duplication under any in_valid/out_ready pattern.

Decomposition:
- Shared package (word_byte_pkg):
  - WORD_W=16 and BYTE_W=8.
  - A phase encoding constant (PH_FIRST=0, PH_SECOND=1).
  - A level-width helper function.
- One natural sub-module: sync_word_fifo.
  - Parameterised width/depth; push/pop/full/empty/level.
  - Asynchronous active-low reset.
- The serializer top holds the output register, the phase bit and the load/handshake logic.

Test Plan:
- Reset then a single word: in_data=16'hA55A with LSB_FIRST=1, out_ready=1.
  -> out_data 8'h5A (out_last=0), then 8'hA5 (out_last=1), then out_valid=0.
- Same word with LSB_FIRST=0.
  -> 8'hA5 then 8'h5A.
- Back-to-back words 16'h0102, 16'h0304, 16'h0506 with in_valid held and out_ready=1.
  -> bytes 02,01,04,03,06,05 on consecutive cycles with no gap. fifo_level never exceeds 2.
- Backpressure with out_ready=0:
  - Push 16'h1111, 16'h2222, 16'h3333.
  - -> the first word is loaded, fifo_level=2, in_ready=0, and out_data stays 8'h11 stable.
  - Release out_ready -> all six bytes arrive in order.
- Random in_valid/out_ready over 10k cycles.
  -> the scoreboard byte stream equals the serialized input stream exactly.
- Assert rst_n=0 while byte 1 of 16'hBEEF is presented and 16'hCAFE is queued.
  -> out_valid=0 and fifo_level=0 immediately; after release, only newly pushed words appear.

Source files
------------

// File: rtl/word16_to_byte_serializer_pkg.sv
// Shared widths, phase encoding and sizing helper for the word-to-byte serializer.
package word_byte_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  // Bits needed to count 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/word16_to_byte_serializer_fifo.sv
// Synchronous word FIFO with occupancy count; power-of-two depth so pointers wrap naturally.
module sync_word_fifo
  import word_byte_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == LVL_W'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is not reset; the count guards every read, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word16_to_byte_serializer.sv
// Splits each 16-bit word into two bytes on a valid/ready stream, buffered by a small word FIFO.
module word16_to_byte_serializer
  import word_byte_pkg::*;
#(
  parameter bit LSB_FIRST  = 1'b1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WORD_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [BYTE_W-1:0]                 out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [level_w(FIFO_DEPTH)-1:0]    fifo_level
);

  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              load;

  logic [WORD_W-1:0] word_q,  word_d;
  logic              valid_q, valid_d;
  phase_e            phase_q, phase_d;

  // Full status comes from registered state only, so in_ready never depends on out_ready.
  assign in_ready = rst_n && !fifo_full;

  // A new word is taken when the register is idle or its second byte is leaving now.
  assign load = !fifo_empty &&
                (!valid_q || (out_ready && phase_q == PH_SECOND));

  sync_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (load),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      phase_q <= PH_FIRST;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    phase_d = phase_q;
    if (load) begin
      word_d  = fifo_head;
      valid_d = 1'b1;
      phase_d = PH_FIRST;
    end else if (valid_q && out_ready) begin
      if (phase_q == PH_FIRST) begin
        phase_d = PH_SECOND;
      end else begin
        // Phase is left at PH_SECOND so the idle out_data keeps showing the last byte sent.
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid = valid_q;
    out_last  = valid_q && (phase_q == PH_SECOND);
    if ((phase_q == PH_SECOND) == LSB_FIRST) begin
      out_data = word_q[WORD_W-1:BYTE_W];
    end else begin
      out_data = word_q[BYTE_W-1:0];
    end
  end

endmodule

// File: tb/tb_word16_to_byte_serializer.sv
// Scoreboarded bench driving an LSB-first and an MSB-first serializer from one stimulus stream.
module tb_word16_to_byte_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_l, out_valid_l, out_last_l;
  logic [7:0]  out_data_l;
  logic [1:0]  fifo_level_l;
  logic        in_ready_m, out_valid_m, out_last_m;
  logic [7:0]  out_data_m;
  logic [1:0]  fifo_level_m;

  int tests = 0;
  int fails = 0;

  logic [8:0] q_lsb [$];
  logic [8:0] q_msb [$];

  word16_to_byte_serializer #(.LSB_FIRST(1'b1), .FIFO_DEPTH(2)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l),
    .fifo_level(fifo_level_l)
  );

  word16_to_byte_serializer #(.LSB_FIRST(1'b0), .FIFO_DEPTH(2)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m),
    .fifo_level(fifo_level_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees exactly what the next edge commits.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (!rst_n) begin
      q_lsb.delete();
      q_msb.delete();
    end else begin
      if (in_valid && in_ready_l) begin
        q_lsb.push_back({1'b0, in_data[7:0]});
        q_lsb.push_back({1'b1, in_data[15:8]});
        q_msb.push_back({1'b0, in_data[15:8]});
        q_msb.push_back({1'b1, in_data[7:0]});
      end
      if (out_valid_l && out_ready) begin
        tests++;
        if (q_lsb.size() == 0) begin
          fails++;
          $display("FAIL sb_lsb: got byte %h last %b, expected no byte", out_data_l, out_last_l);
        end else begin
          exp = q_lsb.pop_front();
          if ({out_last_l, out_data_l} !== exp) begin
            fails++;
            $display("FAIL sb_lsb: got last/byte %b/%h, expected %b/%h",
                     out_last_l, out_data_l, exp[8], exp[7:0]);
          end
        end
      end
      if (out_valid_m && out_ready) begin
        tests++;
        if (q_msb.size() == 0) begin
          fails++;
          $display("FAIL sb_msb: got byte %h last %b, expected no byte", out_data_m, out_last_m);
        end else begin
          exp = q_msb.pop_front();
          if ({out_last_m, out_data_m} !== exp) begin
            fails++;
            $display("FAIL sb_msb: got last/byte %b/%h, expected %b/%h",
                     out_last_m, out_data_m, exp[8], exp[7:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    logic acc;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      acc = in_ready_l;
      step();
      if (acc) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL push_timeout: word %h never accepted, required acceptance within 200 cycles", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (!out_valid_l && !out_valid_m && q_lsb.size() == 0 && q_msb.size() == 0) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain: %0d/%0d bytes still expected, required 0/0", q_lsb.size(), q_msb.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    tests++;
    if ({out_valid_l, out_last_l, out_data_l, fifo_level_l, in_ready_l} !== 13'd0) begin
      fails++;
      $display("FAIL reset_lsb: valid/last/data/level/ready %b/%b/%h/%0d/%b, required all 0",
               out_valid_l, out_last_l, out_data_l, fifo_level_l, in_ready_l);
    end
    tests++;
    if ({out_valid_m, out_last_m, out_data_m, fifo_level_m, in_ready_m} !== 13'd0) begin
      fails++;
      $display("FAIL reset_msb: valid/last/data/level/ready %b/%b/%h/%0d/%b, required all 0",
               out_valid_m, out_last_m, out_data_m, fifo_level_m, in_ready_m);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready %b/%b, required 1/1", in_ready_l, in_ready_m);
    end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hA55A;
    step();
    in_valid = 1'b0;
    tests++;
    if (out_valid_l !== 1'b0 || fifo_level_l !== 2'd1) begin
      fails++;
      $display("FAIL single_accept: valid %b level %0d, required 0 and 1", out_valid_l, fifo_level_l);
    end
    step();
    tests++;
    if ({out_valid_l, out_last_l, out_data_l} !== {2'b10, 8'h5A} ||
        {out_valid_m, out_last_m, out_data_m} !== {2'b10, 8'hA5}) begin
      fails++;
      $display("FAIL single_byte0: lsb %b/%b/%h msb %b/%b/%h, required 1/0/5a and 1/0/a5",
               out_valid_l, out_last_l, out_data_l, out_valid_m, out_last_m, out_data_m);
    end
    step();
    tests++;
    if ({out_valid_l, out_last_l, out_data_l} !== {2'b11, 8'hA5} ||
        {out_valid_m, out_last_m, out_data_m} !== {2'b11, 8'h5A}) begin
      fails++;
      $display("FAIL single_byte1: lsb %b/%b/%h msb %b/%b/%h, required 1/1/a5 and 1/1/5a",
               out_valid_l, out_last_l, out_data_l, out_valid_m, out_last_m, out_data_m);
    end
    step();
    tests++;
    if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0 || out_last_l !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: valid %b/%b last %b, required 0/0/0", out_valid_l, out_valid_m, out_last_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [7:0]  exp_b [6];
    logic [7:0]  got   [6];
    int n, first, last;
    words = '{16'h0102, 16'h0304, 16'h0506};
    exp_b = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05};
    n = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) begin
        in_valid = 1'b1;
        in_data  = words[c];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid_l) begin
        if (n < 6) got[n] = out_data_l;
        if (first < 0) first = c;
        last = c;
        n++;
      end
      tests++;
      if (fifo_level_l > 2'd2) begin
        fails++;
        $display("FAIL b2b_level: fifo_level %0d at cycle %0d, required <= 2", fifo_level_l, c);
      end
    end
    tests++;
    if (n != 6 || last - first != 5) begin
      fails++;
      $display("FAIL b2b_gapless: %0d bytes over cycles %0d..%0d, required 6 consecutive", n, first, last);
    end
    for (int i = 0; i < 6 && i < n; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin
        fails++;
        $display("FAIL b2b_byte%0d: got %h, required %h", i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (fifo_level_l !== 2'd2 || in_ready_l !== 1'b0 || out_valid_l !== 1'b1 ||
          out_data_l !== 8'h11 || out_last_l !== 1'b0) begin
        fails++;
        $display("FAIL stall: level/ready/valid/data/last %0d/%b/%b/%h/%b, required 2/0/1/11/0",
                 fifo_level_l, in_ready_l, out_valid_l, out_data_l, out_last_l);
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (fifo_level_l > 2'd2) begin
        tests++;
        fails++;
        $display("FAIL rand_level: fifo_level %0d, required <= 2", fifo_level_l);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b0;
    push_word(16'hBEEF);
    push_word(16'hCAFE);
    step();
    tests++;
    if (out_valid_l !== 1'b1 || out_data_l !== 8'hEF || fifo_level_l !== 2'd1) begin
      fails++;
      $display("FAIL midrst_setup: valid/data/level %b/%h/%0d, required 1/ef/1",
               out_valid_l, out_data_l, fifo_level_l);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid_l !== 1'b0 || fifo_level_l !== 2'd0 || in_ready_l !== 1'b0 || out_data_l !== 8'h00) begin
      fails++;
      $display("FAIL midrst_async: valid/level/ready/data %b/%0d/%b/%h, required 0/0/0/00",
               out_valid_l, fifo_level_l, in_ready_l, out_data_l);
    end
    step();
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0) begin
      fails++;
      $display("FAIL midrst_release: ready %b valid %b, required 1 and 0", in_ready_l, out_valid_l);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (out_valid_l !== 1'b0) begin
        fails++;
        $display("FAIL midrst_stale: byte %h emitted after reset, required none", out_data_l);
      end
    end
    push_word(16'h1234);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
